ifu_fetch: RTL and testbench

- Instruction fetch unit. Drives the instruction word `I` and its valid flag `W_IR_valid` into the multi-cycle controller.
- Consumes the controller's `write_ir`, `write_pc`, `pc_s` and `imm24`.
- Owns the PC and IR registers and runs a request/acknowledge handshake to instruction memory of variable latency.

---
 rtl/ifu_fetch_pkg.sv | 23 ++
 rtl/ifu_next_pc.sv | 28 ++
 rtl/ifu_fetch.sv | 115 +++++++++++
 tb/tb_ifu_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PC_S_INC = 2'd0;
    localparam logic [1:0] PC_S_BR  = 2'd1;
    localparam logic [1:0] PC_S_ALU = 2'd2;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] BR_PC_OFS = 32'd8;

    // Word offset of a branch: sign-extended imm24 scaled to bytes.
    function automatic logic [31:0] br_offset(input logic [23:0] imm24);
        return {{6{imm24[23]}}, imm24, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// rtl/ifu_next_pc.sv - combinational next-PC select and branch target adder
module ifu_next_pc
    import ifu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir_pc,
    input  logic [1:0]  pc_s,
    input  logic [23:0] imm24,
    input  logic [31:0] alu_f,
    output logic [31:0] next_pc
);

    logic [31:0] br_target;

    // Branch base is the fetch address of the current instruction plus the pipeline offset.
    assign br_target = ir_pc + BR_PC_OFS + br_offset(imm24);

    always_comb begin
        next_pc = pc;
        case (pc_s)
            PC_S_INC: next_pc = pc + PC_STEP;
            PC_S_BR:  next_pc = br_target;
            PC_S_ALU: next_pc = {alu_f[31:2], 2'b00};
            default:  next_pc = pc;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - PC/IR owner with variable-latency instruction memory handshake
// Optional fetch watchdog enabled by defining IFU_FETCH_TIMEOUT_EN.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_ir,
    input  logic        write_pc,
    input  logic [1:0]  pc_s,
    input  logic [23:0] imm24,
    input  logic [31:0] alu_f,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] I,
    output logic        W_IR_valid,
    output logic [31:0] pc,
    output logic [31:0] ir_pc,
    output logic        fetch_err
);

    fetch_state_t state;
    logic [31:0]  next_pc;

    ifu_next_pc u_next_pc (
        .pc      (pc),
        .ir_pc   (ir_pc),
        .pc_s    (pc_s),
        .imm24   (imm24),
        .alu_f   (alu_f),
        .next_pc (next_pc)
    );

`ifdef IFU_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             timed_out;

    // Final unacknowledged cycle of the allowed window.
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fetch_err = err_q;
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign fetch_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            I          <= '0;
            ir_pc      <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            W_IR_valid <= 1'b0;
`ifdef IFU_FETCH_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            // PC update is independent of the fetch handshake.
            if (write_pc) begin
                pc <= next_pc;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (write_ir) begin
                        imem_addr  <= {pc[31:2], 2'b00};
                        imem_req   <= 1'b1;
                        W_IR_valid <= 1'b0;
                        state      <= ST_REQ;
`ifdef IFU_FETCH_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end else if (state == ST_IDLE) begin
                        W_IR_valid <= 1'b0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (imem_ack) begin
                        I          <= imem_rdata;
                        ir_pc      <= imem_addr;
                        imem_req   <= 1'b0;
                        W_IR_valid <= 1'b1;
                        state      <= ST_DONE;
`ifdef IFU_FETCH_TIMEOUT_EN
                    end else if (timed_out) begin
                        imem_req   <= 1'b0;
                        err_q      <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        wait_cnt   <= wait_cnt + 1'b1;
                        state      <= ST_WAIT;
`else
                    end else begin
                        state      <= ST_WAIT;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized and directed checks of ifu_fetch against a transaction model
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TMO    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write_ir = 1'b0;
    logic        write_pc = 1'b0;
    logic [1:0]  pc_s = 2'd0;
    logic [23:0] imm24 = '0;
    logic [31:0] alu_f = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] d_I;
    logic        W_IR_valid;
    logic [31:0] pc;
    logic [31:0] ir_pc;
    logic        fetch_err;

    ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_ir   (write_ir),
        .write_pc   (write_pc),
        .pc_s       (pc_s),
        .imm24      (imm24),
        .alu_f      (alu_f),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .I          (d_I),
        .W_IR_valid (W_IR_valid),
        .pc         (pc),
        .ir_pc      (ir_pc),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: one in-flight fetch at most.
    logic [31:0] m_pc, m_I, m_ir_pc, m_addr;
    bit          m_busy, m_valid, m_err;
    int          m_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_I = 0; m_ir_pc = 0; m_addr = 0;
        m_busy = 0; m_valid = 0; m_err = 0; m_wait = 0;
    endtask

    task automatic model_update();
        logic [31:0] npc;
        if (!rst) begin
            model_reset();
            return;
        end
        npc = m_pc;
        if (write_pc) begin
            if (pc_s == 2'd0) npc = m_pc + 32'd4;
            else if (pc_s == 2'd1) npc = m_ir_pc + 32'd8 + ({{8{imm24[23]}}, imm24} * 32'd4);
            else if (pc_s == 2'd2) npc = alu_f - (alu_f % 32'd4);
        end
        if (m_busy) begin
            if (imem_ack) begin
                m_I = imem_rdata; m_ir_pc = m_addr; m_busy = 0; m_valid = 1;
            end else begin
`ifdef IFU_FETCH_TIMEOUT_EN
                m_wait++;
                if (m_wait == TMO) begin m_busy = 0; m_err = 1; end
`endif
            end
        end else if (write_ir) begin
            m_addr = m_pc - (m_pc % 32'd4); m_busy = 1; m_valid = 0; m_wait = 0;
        end
        m_pc = npc;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("I", d_I, m_I);
            check("ir_pc", ir_pc, m_ir_pc);
            check("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
            if (m_busy) check("imem_addr", imem_addr, m_addr);
            check("W_IR_valid", {31'd0, W_IR_valid}, {31'd0, m_valid});
            check("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        write_ir = 0; write_pc = 0; pc_s = 0; imm24 = 0; alu_f = 0; imem_ack = 0;
    endtask

    task automatic set_pc(input logic [1:0] s, input logic [31:0] a, input logic [23:0] im);
        write_pc = 1; pc_s = s; alu_f = a; imm24 = im;
        tick();
        clear_in();
    endtask

    task automatic fetch_now(input logic [31:0] data);
        write_ir = 1;
        tick();
        write_ir = 0; imem_ack = 1; imem_rdata = data;
        tick();
        imem_ack = 0;
    endtask

    initial begin
        model_reset();
        chk_en = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_I", d_I, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        rst = 1;
        tick();
        check("post_rst_pc", pc, 32'h100);
        check("post_rst_valid", {31'd0, W_IR_valid}, 32'd0);

        // Fetch acknowledged on the third request cycle.
        write_ir = 1;
        tick();
        write_ir = 0;
        for (int i = 0; i < 3; i++) begin
            check("lat_addr", imem_addr, 32'h100);
            check("lat_req", {31'd0, imem_req}, 32'd1);
            if (i == 2) begin imem_ack = 1; imem_rdata = 32'hE081_0002; end
            tick();
        end
        imem_ack = 0;
        check("lat_I", d_I, 32'hE081_0002);
        check("lat_ir_pc", ir_pc, 32'h100);
        check("lat_valid", {31'd0, W_IR_valid}, 32'd1);
        check("lat_req_drop", {31'd0, imem_req}, 32'd0);

        // Same-cycle fetch and PC increment.
        write_ir = 1; write_pc = 1; pc_s = 2'd0;
        tick();
        clear_in();
        check("step_pc", pc, 32'h104);
        check("step_addr", imem_addr, 32'h100);
        check("step_valid", {31'd0, W_IR_valid}, 32'd0);
        imem_ack = 1; imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 0;

        // Branches relative to ir_pc = 0x200.
        set_pc(2'd2, 32'h200, 24'd0);
        fetch_now(32'hA5A5_0001);
        check("br_ir_pc", ir_pc, 32'h200);
        set_pc(2'd1, 32'd0, 24'hFFFFFE);
        check("br_back", pc, 32'h200);
        set_pc(2'd1, 32'd0, 24'h000010);
        check("br_fwd", pc, 32'h248);

        // ALU write, then write_ir held during the request.
        set_pc(2'd2, 32'h1237, 24'd0);
        check("alu_pc", pc, 32'h1234);
        write_ir = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_addr", imem_addr, 32'h1234);
        end
        write_ir = 0; imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ack = 0;
        check("hold_I", d_I, 32'hCAFE_F00D);
        tick();
        check("single_req", {31'd0, imem_req}, 32'd0);

        // Wraparound and reserved select.
        set_pc(2'd2, 32'hFFFF_FFFF, 24'd0);
        set_pc(2'd0, 32'd0, 24'd0);
        check("wrap_pc", pc, 32'd0);
        set_pc(2'd3, 32'h5555_5555, 24'd0);
        check("hold_pc", pc, 32'd0);

        // Reset during WAIT, late ack ignored.
        write_ir = 1;
        tick();
        write_ir = 0;
        tick();
        rst = 0;
        model_reset();
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1;
        tick();
        imem_ack = 0;
        check("late_ack_I", d_I, 32'd0);
        check("late_ack_valid", {31'd0, W_IR_valid}, 32'd0);

`ifdef IFU_FETCH_TIMEOUT_EN
        write_ir = 1;
        tick();
        write_ir = 0;
        for (int i = 0; i < TMO; i++) begin
            check("tmo_req", {31'd0, imem_req}, 32'd1);
            tick();
        end
        check("tmo_drop", {31'd0, imem_req}, 32'd0);
        check("tmo_err", {31'd0, fetch_err}, 32'd1);
        check("tmo_I", d_I, 32'd0);
        rst = 0;
        model_reset();
        tick();
        rst = 1;
        tick();
`endif

        // Randomized traffic, including stray acks.
        for (int n = 0; n < 600; n++) begin
            write_ir   = ($urandom_range(0, 9) < 3);
            write_pc   = ($urandom_range(0, 9) < 3);
            pc_s       = 2'($urandom_range(0, 3));
            imm24      = 24'($urandom);
            alu_f      = $urandom;
            imem_ack   = ($urandom_range(0, 9) < 4);
            imem_rdata = $urandom;
            tick();
        end
        clear_in();
        tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
